// File: rtl/pipe_pkg.sv
// Shared encodings for the rv32 pipeline memory path.
// State values are fixed because they show up in waveforms and debug dumps.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_D  = 2'd2
    } arb_state_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; flags when fetch must win.
module starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    logic [3:0] count;

    // A clear wins over an increment, and the count sticks at 15.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && (count != 4'hF)) begin
            count <= count + 4'd1;
        end
    end

    assign starved = (count >= 4'(STARVE_MAX));

endmodule

// File: rtl/mem_arb.sv
// Arbiter for the unified memory port shared by fetch and data access.
// One transaction is outstanding at a time; responses route to the owner.
module mem_arb
    import pipe_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        if_flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    arb_state_t state, state_next;
    logic       drop, drop_next;
    logic       window, sel_if, sel_d, starved;

    starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (if_req && !if_gnt),
        .clr    (if_gnt),
        .starved(starved)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
        end
    end

    // Window is gated by reset so that nothing leaks onto the port while held in reset.
    always_comb begin
        window     = 1'b0;
        sel_if     = 1'b0;
        sel_d      = 1'b0;
        state_next = state;
        drop_next  = drop;
        if (rst) begin
            window = (state == IDLE) || mem_rvalid;
        end
        if (window) begin
            if (starved && if_req) begin
                sel_if = 1'b1;
            end else if (d_req) begin
                sel_d = 1'b1;
            end else if (if_req) begin
                sel_if = 1'b1;
            end
            state_next = if_gnt ? OWN_IF : (d_gnt ? OWN_D : IDLE);
        end
        if ((state == OWN_IF) && mem_rvalid) begin
            drop_next = 1'b0;
        end else if ((state == OWN_IF) && if_flush) begin
            drop_next = 1'b1;
        end
    end

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if_rvalid = 1'b0;
        if_rdata  = 32'h0;
        d_rvalid  = 1'b0;
        d_rdata   = 32'h0;
        if (sel_if) begin
            mem_req  = 1'b1;
            mem_be   = BE_ALL;
            mem_addr = if_addr;
            if_gnt   = mem_ready;
        end else if (sel_d) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_be    = d_we ? d_be : BE_ALL;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            d_gnt     = mem_ready;
        end
        // A flush arriving with the response kills it just like a recorded drop.
        if ((state == OWN_IF) && mem_rvalid && !drop && !if_flush) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
        end
        if ((state == OWN_D) && mem_rvalid) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: response scoreboard plus per-scenario grant checks.
module tb_mem_arb;

    typedef struct {
        logic [1:0]  port;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [3:0]  d_be = 4'h0;
    logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int    vectors = 0;
    int    miscompares = 0;
    resp_t exp_q[$];
    resp_t e;

    // Port code 1 = fetch, 2 = data, 0 = no response, 3 = both (always wrong).
    wire [1:0]  obs_port = {d_rvalid, if_rvalid};
    wire [31:0] obs_data = d_rvalid ? d_rdata : (if_rvalid ? if_rdata : 32'h0);

    mem_arb #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_flush(if_flush),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, busy, mem_addr} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: gnt=%b%b rvalid=%b%b mem_req=%b busy=%b addr=%h, expected all 0",
                     if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, busy, mem_addr);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_starvation();
        byte grants[6] = '{"D", "D", "D", "D", "I", "D"};
        byte obs;
        mem_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if_req = (k < 6);
            d_req  = (k < 6);
            d_we   = 1'b0;
            mem_rvalid = (k > 0);
            mem_rdata  = 32'hA000_0000 + 32'(k);
            if (k > 0) exp_q.push_back('{(grants[k-1] == "I") ? 2'd1 : 2'd2, mem_rdata});
            @(negedge clk);
            if (k > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({obs_port, obs_data} !== {e.port, e.data}) begin
                    miscompares++;
                    $display("[TB] FAIL starve_resp%0d: port=%0d data=%h, expected port=%0d data=%h",
                             k, obs_port, obs_data, e.port, e.data);
                end
            end
            if (k < 6) begin
                obs = if_gnt ? "I" : (d_gnt ? "D" : "-");
                vectors++;
                if ((obs !== grants[k]) || (if_gnt && d_gnt)) begin
                    miscompares++;
                    $display("[TB] FAIL starve_grant%0d: got %c, expected %c", k, obs, grants[k]);
                end
            end
            if (k == 5) begin
                vectors++;
                if (dut.u_starve.count !== 4'd0) begin
                    miscompares++;
                    $display("[TB] FAIL starve_clear: count=%0d, expected 0", dut.u_starve.count);
                end
            end
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_simultaneous();
        tick();
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b1010; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        @(negedge clk);
        vectors++;
        if ({d_gnt, if_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
            {1'b1, 1'b0, 1'b1, 1'b1, 4'b1010, 32'h200, 32'h1234_5678}) begin
            miscompares++;
            $display("[TB] FAIL simul_grant: d_gnt=%b if_gnt=%b we=%b be=%b addr=%h wdata=%h, expected 1 0 1 1010 200 12345678",
                     d_gnt, if_gnt, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick();
        if_req = 1'b0; d_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        exp_q.push_back('{2'd2, 32'hDEADBEEF});
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if ({obs_port, obs_data} !== {e.port, e.data}) begin
            miscompares++;
            $display("[TB] FAIL simul_resp: port=%0d data=%h, expected port=%0d data=%h",
                     obs_port, obs_data, e.port, e.data);
        end
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL simul_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_flush();
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        @(negedge clk);
        vectors++;
        if ({if_gnt, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h40, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL flush_grant: if_gnt=%b we=%b be=%h addr=%h wdata=%h, expected 1 0 f 40 0",
                     if_gnt, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick();
        if_req = 1'b0; if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        tick();
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        exp_q.push_back('{2'd0, 32'h0});
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if ({obs_port, obs_data, busy} !== {e.port, e.data, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL flush_drop: port=%0d data=%h busy=%b, expected port=%0d data=%h busy=1",
                     obs_port, obs_data, busy, e.port, e.data);
        end
        tick();
        mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        @(negedge clk);
        vectors++;
        if ({busy, if_gnt, mem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            miscompares++;
            $display("[TB] FAIL flush_refetch: busy=%b if_gnt=%b addr=%h, expected 0 1 100", busy, if_gnt, mem_addr);
        end
        tick();
        if_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h00C0_0093;
        exp_q.push_back('{2'd1, 32'h00C0_0093});
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if ({obs_port, obs_data} !== {e.port, e.data}) begin
            miscompares++;
            $display("[TB] FAIL flush_newpath: port=%0d data=%h, expected port=%0d data=%h",
                     obs_port, obs_data, e.port, e.data);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        tick();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'b0001; d_addr = 32'h300;
        @(negedge clk);
        vectors++;
        if ({d_gnt, mem_we, mem_be} !== {1'b1, 1'b0, 4'hF}) begin
            miscompares++;
            $display("[TB] FAIL b2b_load: d_gnt=%b we=%b be=%h, expected 1 0 f", d_gnt, mem_we, mem_be);
        end
        tick();
        d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h304; d_wdata = 32'h0000_CAFE;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        exp_q.push_back('{2'd2, 32'h1111_2222});
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if ({obs_port, obs_data, d_gnt, mem_req, mem_we, mem_be, mem_wdata} !==
            {e.port, e.data, 1'b1, 1'b1, 1'b1, 4'b0011, 32'h0000_CAFE}) begin
            miscompares++;
            $display("[TB] FAIL b2b_issue: port=%0d data=%h gnt=%b req=%b we=%b be=%b wdata=%h, expected %0d %h 1 1 1 0011 0000cafe",
                     obs_port, obs_data, d_gnt, mem_req, mem_we, mem_be, mem_wdata, e.port, e.data);
        end
        tick();
        d_req = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, dut.state} !== {1'b1, 2'd2}) begin
            miscompares++;
            $display("[TB] FAIL b2b_state: busy=%b state=%0d, expected 1 2", busy, dut.state);
        end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0;
        exp_q.push_back('{2'd2, 32'h0});
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if ({obs_port, obs_data} !== {e.port, e.data}) begin
            miscompares++;
            $display("[TB] FAIL b2b_store_ack: port=%0d, expected port=%0d", obs_port, e.port);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        tick();
        if_req = 1'b1; if_addr = 32'h500; mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if ({mem_req, if_gnt, busy} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL bp_wait%0d: mem_req=%b if_gnt=%b busy=%b, expected 1 0 0", k, mem_req, if_gnt, busy);
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (if_gnt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_grant: if_gnt=%b, expected 1", if_gnt);
        end
        tick();
        if_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_0001;
        exp_q.push_back('{2'd1, 32'h5555_0001});
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if ({obs_port, obs_data} !== {e.port, e.data}) begin
            miscompares++;
            $display("[TB] FAIL bp_resp: port=%0d data=%h, expected port=%0d data=%h", obs_port, obs_data, e.port, e.data);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        if_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rmid_busy: busy=%b, expected 1", busy);
        end
        #2;
        rst = 1'b0; if_req = 1'b1; d_req = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, busy, mem_be, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL rmid_outputs: gnt=%b%b rvalid=%b%b req=%b busy=%b, expected all 0",
                     if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, busy);
        end
        tick();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        exp_q.push_back('{2'd0, 32'h0});
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if ({obs_port, obs_data, busy} !== {e.port, e.data, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL rmid_stray: port=%0d data=%h busy=%b, expected port=%0d busy=0", obs_port, obs_data, busy, e.port);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_starvation();
        test_simultaneous();
        test_flush();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates the single unified memory port between the fetch stage (instruction reads) and the access stage (loads/stores) of the rv32 pipeline.
- Tracks one outstanding transaction and routes each memory response back to the requester that owns it.
- Data accesses win by default. A starvation counter guarantees fetch progress.
- A fetch flush (taken branch/JALR redirect) discards a stale in-flight fetch response.

Parameters:
- STARVE_MAX, 4, number of consecutive denied fetch cycles after which fetch gets priority for one grant (legal range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request, held until granted
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- if_flush  in  1  discard any in-flight fetch response
- d_req  in  1  data request, held until granted
- d_we  in  1  1=store, 0=load
- d_be  in  4  store byte enables
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store ack
- d_rdata  out  32  load data
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_be  out  4  byte enables to memory (4'hF on reads)
- mem_addr  out  32  address to memory
- mem_wdata  out  32  write data to memory
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response valid (reads and writes)
- mem_rdata  in  32  memory read data
- busy  out  1  a transaction is outstanding

Behaviour:
- Reset (rst=0, async): state=IDLE, starve_cnt=0, drop=0. All outputs 0: gnts, rvalids, mem_req, busy, data buses.
- States:
  - IDLE: no transaction outstanding.
  - OWN_IF: fetch transaction outstanding.
  - OWN_D: data transaction outstanding.
- Arbitration window is open when state=IDLE, or when state is busy and mem_rvalid=1 (back-to-back issue in the response cycle).
- Selection in the open window:
  - If starve_cnt>=STARVE_MAX and if_req: select fetch.
  - Else if d_req: select data.
  - Else if if_req: select fetch.
  - Else no selection.
- Request path is combinational from the selected requester:
  - mem_req=1 and fields driven.
  - Fetch drives mem_we=0, mem_be=4'hF, mem_wdata=0.
  - Unselected or idle: mem_req=0 and mem_* fields 0.
- Grant: x_gnt = selected & mem_ready, same cycle. On grant, next state is OWN_IF or OWN_D. If the window opened and nothing was granted, next state is IDLE.
- Response routing: mem_rvalid in OWN_D gives d_rvalid=1, d_rdata=mem_rdata. In OWN_IF it gives if_rvalid=1, if_rdata=mem_rdata, unless drop=1. Rvalid outputs are combinational, zero latency from mem_rvalid.
- mem_rvalid in IDLE is ignored and produces no rvalid.
- Stores also complete with mem_rvalid. d_rvalid pulses; d_rdata = mem_rdata (don't-care to consumer).
- Flush:
  - if_flush in OWN_IF without mem_rvalid sets drop=1.
  - if_flush in the same cycle as the OWN_IF mem_rvalid suppresses if_rvalid that cycle.
  - drop clears when the owned response arrives.
  - if_flush in IDLE/OWN_D has no effect.
  - A fetch granted in the flush cycle is a new-path fetch and is not dropped.
- Starvation counter (4-bit, saturating at 15):
  - Increments each cycle if_req=1 and if_gnt=0.
  - Clears on if_gnt.
  - Holds when if_req=0.
- busy = (state != IDLE).
- Memory latency is unbounded; the arbiter waits in OWN_x indefinitely. A request is never withdrawn by the arbiter once mem_req is driven for a granted requester.
- Async reset mid-transaction returns to IDLE immediately. Any later mem_rvalid is ignored as above.

Decomposition:
- Shared package pipe_pkg: state encoding (IDLE=2'd0, OWN_IF=2'd1, OWN_D=2'd2) and constant BE_ALL=4'hF.
- Sub-module: starve_cnt (saturating counter with clear/inc/threshold compare), instantiated once. All else stays in mem_arb.

Test Plan:
- Simultaneous requests: if_req=d_req=1, IDLE, mem_ready=1 -> d_gnt=1, if_gnt=0, mem_we=d_we. Response with mem_rdata=32'hDEADBEEF -> d_rvalid=1, d_rdata=32'hDEADBEEF, if_rvalid=0.
- Starvation: d_req and if_req held high, 1-cycle memory latency, STARVE_MAX=4 -> data is granted until starve_cnt reaches 4. The next grant goes to fetch, then data resumes priority; the counter reads 0 after the fetch grant.
- Flush: fetch granted at 32'h0000_0040, if_flush pulsed 1 cycle later, mem_rvalid 3 cycles later with 32'h0000_0013 -> if_rvalid stays 0, busy drops. A following fetch at 32'h0000_0100 returns normally.
- Back-to-back: in OWN_D, mem_rvalid=1 with d_req=1 for a store (d_be=4'b0011) -> new mem_req is issued in the same cycle with mem_be=4'b0011, and state stays OWN_D.
- Backpressure: mem_ready=0 for 5 cycles with if_req=1 -> mem_req=1 every cycle, if_gnt=0, state IDLE. Grant follows in the cycle mem_ready=1.
- Reset mid-operation: rst=0 while in OWN_IF -> all outputs 0 asynchronously. After release, a stray mem_rvalid produces no if_rvalid or d_rvalid.
